// File: rtl/frequency_mac_stage_pkg.sv
// Shared constants for the per-bin frequency-domain MAC stage.
// Saturation is selected by defining FREQ_MAC_SAT_EN.
package frequency_mac_stage_pkg;

  localparam int W      = 16;
  localparam int FRAC   = 14;
  localparam int NFFT   = 32;
  localparam int KW     = 5;
  localparam int PROD_W = 2 * W;
  // Four 2W-bit products summed never exceed 2W+2 signed bits.
  localparam int ACC_W  = 2 * W + 2;

  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(2 ** (W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-(2 ** (W - 1)));
  localparam logic [KW-1:0]           LAST_BIN   = KW'(NFFT - 1);

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/frequency_mac_stage_cmul_round_sat.sv
// Round-half-up rescale of one accumulator component to W bits.
// With FREQ_MAC_SAT_EN the result clamps and flags; otherwise it wraps.
module cmul_round_sat
  import frequency_mac_stage_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  output logic [W-1:0]     o_y,
  output logic             o_sat
);

`ifdef FREQ_MAC_SAT_EN
  logic signed [ACC_W-1:0] w_rnd;

  assign w_rnd = ($signed(i_acc) + ROUND_HALF) >>> FRAC;

  always_comb begin
    o_y   = W'(w_rnd);
    o_sat = 1'b0;
    if (w_rnd > SAT_MAX) begin
      o_y   = W'(SAT_MAX);
      o_sat = 1'b1;
    end else if (w_rnd < SAT_MIN) begin
      o_y   = W'(SAT_MIN);
      o_sat = 1'b1;
    end
  end
`else
  assign o_y   = W'(($signed(i_acc) + ROUND_HALF) >>> FRAC);
  assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/frequency_mac_stage.sv
// Three-stage complex MAC: Y[k] = W0*X_curr + W1*X_old, with bin/frame tagging.
// Optional clamp of the rescaled result via FREQ_MAC_SAT_EN.
module frequency_mac_stage
  import frequency_mac_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [W-1:0]  i_X_curr_re,
  input  logic [W-1:0]  i_X_curr_im,
  input  logic [W-1:0]  i_X_old_re,
  input  logic [W-1:0]  i_X_old_im,
  input  logic [W-1:0]  i_W0_re,
  input  logic [W-1:0]  i_W0_im,
  input  logic [W-1:0]  i_W1_re,
  input  logic [W-1:0]  i_W1_im,
  output logic          o_valid,
  output logic [W-1:0]  o_Y_re,
  output logic [W-1:0]  o_Y_im,
  output logic [KW-1:0] o_k_idx,
  output logic          o_first,
  output logic          o_last,
  output logic          o_short_frame,
  output logic          o_sat
);

  // Handshake: a bin is transferred on every rising edge with i_valid high;
  // there is no ready, so the stage accepts one bin per cycle unconditionally.

  logic                     r_v1, r_v2, r_v3;
  logic signed [PROD_W-1:0] r_p [8];
  logic signed [ACC_W-1:0]  r_acc_re, r_acc_im;
  logic [KW-1:0]            r_in_cnt, r_out_cnt;
  logic                     r_end2, r_short2;
  logic [W-1:0]             r_y_re, r_y_im;
  logic [KW-1:0]            r_k_idx;
  logic                     r_first, r_last, r_short, r_sat;

  logic                     w_end, w_short;
  logic [W-1:0]             w_y_re, w_y_im;
  logic                     w_sat_re, w_sat_im;

  // Stage 1: eight partial products.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      for (int i = 0; i < 8; i++) r_p[i] <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_p[0] <= $signed(i_X_curr_re) * $signed(i_W0_re);
        r_p[1] <= $signed(i_X_curr_im) * $signed(i_W0_im);
        r_p[2] <= $signed(i_X_curr_re) * $signed(i_W0_im);
        r_p[3] <= $signed(i_X_curr_im) * $signed(i_W0_re);
        r_p[4] <= $signed(i_X_old_re)  * $signed(i_W1_re);
        r_p[5] <= $signed(i_X_old_im)  * $signed(i_W1_im);
        r_p[6] <= $signed(i_X_old_re)  * $signed(i_W1_im);
        r_p[7] <= $signed(i_X_old_im)  * $signed(i_W1_re);
      end
    end
  end

  // A run ends the first cycle i_valid is low while the last bin sits in stage 1;
  // at that moment r_in_cnt still holds the run length modulo NFFT.
  assign w_end   = r_v1 & ~i_valid;
  assign w_short = w_end & (r_in_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_cnt <= '0;
    end else if (i_valid) begin
      r_in_cnt <= (r_in_cnt == LAST_BIN) ? '0 : r_in_cnt + KW'(1);
    end else begin
      r_in_cnt <= '0;
    end
  end

  // Stage 2: complex accumulate, plus end-of-run tags travelling with the bin.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2     <= 1'b0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_end2   <= 1'b0;
      r_short2 <= 1'b0;
    end else begin
      r_v2     <= r_v1;
      r_end2   <= w_end;
      r_short2 <= w_short;
      if (r_v1) begin
        r_acc_re <= (sext_prod(r_p[0]) - sext_prod(r_p[1]))
                  + (sext_prod(r_p[4]) - sext_prod(r_p[5]));
        r_acc_im <= (sext_prod(r_p[2]) + sext_prod(r_p[3]))
                  + (sext_prod(r_p[6]) + sext_prod(r_p[7]));
      end
    end
  end

  cmul_round_sat u_rs_re (
    .i_acc (r_acc_re),
    .o_y   (w_y_re),
    .o_sat (w_sat_re)
  );

  cmul_round_sat u_rs_im (
    .i_acc (r_acc_im),
    .o_y   (w_y_im),
    .o_sat (w_sat_im)
  );

  // Stage 3: output registers and output-side bin counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3      <= 1'b0;
      r_y_re    <= '0;
      r_y_im    <= '0;
      r_k_idx   <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_short   <= 1'b0;
      r_sat     <= 1'b0;
      r_out_cnt <= '0;
    end else begin
      r_v3    <= r_v2;
      r_first <= r_v2 & (r_out_cnt == '0);
      r_last  <= r_v2 & (r_out_cnt == LAST_BIN);
      r_short <= r_v2 & r_short2;
      r_sat   <= r_v2 & (w_sat_re | w_sat_im);
      if (r_v2) begin
        r_y_re    <= w_y_re;
        r_y_im    <= w_y_im;
        r_k_idx   <= r_out_cnt;
        r_out_cnt <= (r_end2 || r_out_cnt == LAST_BIN) ? '0 : r_out_cnt + KW'(1);
      end
    end
  end

  assign o_valid       = r_v3;
  assign o_Y_re        = r_y_re;
  assign o_Y_im        = r_y_im;
  assign o_k_idx       = r_k_idx;
  assign o_first       = r_first;
  assign o_last        = r_last;
  assign o_short_frame = r_short;
  assign o_sat         = r_sat;

endmodule

// File: tb/tb_frequency_mac_stage.sv
// Directed bench for frequency_mac_stage; expectations adapt to FREQ_MAC_SAT_EN.
module tb_frequency_mac_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [15:0] i_X_curr_re, i_X_curr_im, i_X_old_re, i_X_old_im;
  logic [15:0] i_W0_re, i_W0_im, i_W1_re, i_W1_im;
  logic        o_valid;
  logic [15:0] o_Y_re, o_Y_im;
  logic [4:0]  o_k_idx;
  logic        o_first, o_last, o_short_frame, o_sat;

  int checks = 0;
  int errors = 0;

  frequency_mac_stage dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_X_curr_re   (i_X_curr_re),
    .i_X_curr_im   (i_X_curr_im),
    .i_X_old_re    (i_X_old_re),
    .i_X_old_im    (i_X_old_im),
    .i_W0_re       (i_W0_re),
    .i_W0_im       (i_W0_im),
    .i_W1_re       (i_W1_re),
    .i_W1_im       (i_W1_im),
    .o_valid       (o_valid),
    .o_Y_re        (o_Y_re),
    .o_Y_im        (o_Y_im),
    .o_k_idx       (o_k_idx),
    .o_first       (o_first),
    .o_last        (o_last),
    .o_short_frame (o_short_frame),
    .o_sat         (o_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] u16(input int v);
    logic [31:0] t;
    t = 32'(v);
    return {16'h0, t[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int xcr, input int xci, input int xor_, input int xoi,
                        input int w0r, input int w0i, input int w1r, input int w1i);
    i_valid     = 1'b1;
    i_X_curr_re = 16'(xcr);
    i_X_curr_im = 16'(xci);
    i_X_old_re  = 16'(xor_);
    i_X_old_im  = 16'(xoi);
    i_W0_re     = 16'(w0r);
    i_W0_im     = 16'(w0i);
    i_W1_re     = 16'(w1r);
    i_W1_im     = 16'(w1i);
  endtask

  task automatic set_idle();
    i_valid     = 1'b0;
    i_X_curr_re = '0;
    i_X_curr_im = '0;
    i_X_old_re  = '0;
    i_X_old_im  = '0;
    i_W0_re     = '0;
    i_W0_im     = '0;
    i_W1_re     = '0;
    i_W1_im     = '0;
  endtask

  // Bin j carries Xc=(1.0,0), W0=(100j,-37j), X_old=(0,1.0), W1=(5,0),
  // so Y = (100j, 5-37j) exactly.
  task automatic stream_check(input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) set_in(16384, 0, 0, 16384, i * 100, -(i * 37), 5, 0);
      else       set_idle();
      cycle();
      if (i >= 2) begin
        int j;
        j = i - 2;
        chk("st_valid", 32'(o_valid), 32'(1));
        chk("st_k_idx", 32'(o_k_idx), 32'(j % 32));
        chk("st_first", 32'(o_first), 32'((j % 32) == 0));
        chk("st_last",  32'(o_last),  32'((j % 32) == 31));
        chk("st_short", 32'(o_short_frame), 32'((j == n - 1) && ((n % 32) != 0)));
        chk("st_y_re",  32'(o_Y_re), u16(j * 100));
        chk("st_y_im",  32'(o_Y_im), u16(5 - j * 37));
      end
    end
    cycle();
    chk("st_idle_valid", 32'(o_valid), 32'(0));
    chk("st_idle_short", 32'(o_short_frame), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    repeat (2) cycle();

    // Reset state
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_y_re",  32'(o_Y_re), 32'(0));
    chk("rst_y_im",  32'(o_Y_im), 32'(0));
    chk("rst_k_idx", 32'(o_k_idx), 32'(0));
    chk("rst_first", 32'(o_first), 32'(0));
    chk("rst_last",  32'(o_last), 32'(0));
    chk("rst_short", 32'(o_short_frame), 32'(0));
    chk("rst_sat",   32'(o_sat), 32'(0));
    rst = 1'b0;
    cycle();

    // 1.0 * 0.5 = 0.5; a lone bin is a short run
    set_in(16384, 0, 0, 0, 8192, 0, 0, 0);
    cycle();
    set_idle();
    cycle();
    chk("t1_early_valid", 32'(o_valid), 32'(0));
    cycle();
    chk("t1_valid", 32'(o_valid), 32'(1));
    chk("t1_y_re",  32'(o_Y_re), u16(8192));
    chk("t1_y_im",  32'(o_Y_im), u16(0));
    chk("t1_sat",   32'(o_sat), 32'(0));
    chk("t1_k_idx", 32'(o_k_idx), 32'(0));
    chk("t1_first", 32'(o_first), 32'(1));
    chk("t1_last",  32'(o_last), 32'(0));
    chk("t1_short", 32'(o_short_frame), 32'(1));
    cycle();
    chk("t1_after_valid", 32'(o_valid), 32'(0));
    chk("t1_hold_y_re",   32'(o_Y_re), u16(8192));
    chk("t1_after_first", 32'(o_first), 32'(0));
    chk("t1_after_short", 32'(o_short_frame), 32'(0));

    // j * j = -1
    set_in(0, 16384, 0, 0, 0, 16384, 0, 0);
    cycle();
    set_idle();
    repeat (2) cycle();
    chk("t2_valid", 32'(o_valid), 32'(1));
    chk("t2_y_re",  32'(o_Y_re), u16(-16384));
    chk("t2_y_im",  32'(o_Y_im), u16(0));
    chk("t2_sat",   32'(o_sat), 32'(0));
    chk("t2_k_idx", 32'(o_k_idx), 32'(0));
    cycle();

    // Full-scale operands overflow W bits
    set_in(32767, 0, 32767, 0, 32767, 0, 32767, 0);
    cycle();
    set_idle();
    repeat (2) cycle();
    chk("t3_valid", 32'(o_valid), 32'(1));
`ifdef FREQ_MAC_SAT_EN
    chk("t3_y_re", 32'(o_Y_re), u16(32767));
    chk("t3_sat",  32'(o_sat), 32'(1));
`else
    chk("t3_y_re", 32'(o_Y_re), u16(-8));
    chk("t3_sat",  32'(o_sat), 32'(0));
`endif
    chk("t3_y_im", 32'(o_Y_im), u16(0));
    cycle();
    chk("t3_after_sat", 32'(o_sat), 32'(0));
    cycle();

    // Two back-to-back full frames, then a short run, then a fresh run
    stream_check(64);
    stream_check(10);
    stream_check(3);

    // Reset in the middle of a frame discards in-flight bins
    for (int i = 0; i < 5; i++) begin
      set_in(16384, 0, 0, 0, 1000 + i, 0, 0, 0);
      cycle();
    end
    rst = 1'b1;
    set_in(16384, 0, 0, 0, 1005, 0, 0, 0);
    cycle();
    rst = 1'b0;
    set_idle();
    cycle();
    chk("t6_valid0", 32'(o_valid), 32'(0));
    chk("t6_y_re",   32'(o_Y_re), 32'(0));
    chk("t6_y_im",   32'(o_Y_im), 32'(0));
    chk("t6_k_idx",  32'(o_k_idx), 32'(0));
    chk("t6_first",  32'(o_first), 32'(0));
    chk("t6_short",  32'(o_short_frame), 32'(0));
    cycle();
    chk("t6_valid1", 32'(o_valid), 32'(0));
    cycle();
    chk("t6_valid2", 32'(o_valid), 32'(0));
    stream_check(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
